// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 16-bit five-stage core: captures decoded
// control and operands, inserts load-use and flush bubbles, and counts them.
module id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic          id_reg_wren,
  input  logic          id_mem_to_reg,
  input  logic          id_mem_wr,
  input  logic          id_alu_src,
  input  logic          id_dst_reg_sel,
  input  logic          id_branch,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc,
  input  logic          stall_in,
  input  logic          flush_in,
  output logic          ex_valid,
  output logic [3:0]    ex_opcode,
  output logic          ex_reg_wren,
  output logic          ex_mem_to_reg,
  output logic          ex_mem_wr,
  output logic          ex_alu_src,
  output logic          ex_branch,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_dst_reg,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc,
  output logic          hazard_stall,
  output logic          stall_up,
  output logic [15:0]   bubble_cnt
);

  logic flush_pend;
  logic uses_rt;
  logic eff_flush;
  logic load_bubble;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Immediate-form ALU ops ignore rt unless the instruction is a store.
  always_comb begin
    uses_rt      = ~id_alu_src | id_mem_wr;
    hazard_stall = id_valid & ex_valid & ex_mem_to_reg & (ex_dst_reg != '0) &
                   ((ex_dst_reg == id_rs) | (uses_rt & (ex_dst_reg == id_rt)));
    stall_up     = stall_in | hazard_stall;
    eff_flush    = (flush_in | flush_pend) & ~stall_in;
    load_bubble  = ~stall_in & (eff_flush | hazard_stall);
  end

  // A flush arriving under stall is remembered until the stage can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flush_pend <= 1'b0;
    else if (stall_in)
      flush_pend <= flush_pend | flush_in;
    else
      flush_pend <= 1'b0;
  end

  // ---- ID -> EX stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_opcode     <= '0;
      ex_reg_wren   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dst_reg    <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_pc         <= '0;
      bubble_cnt    <= '0;
    end else if (!stall_in) begin
      if (load_bubble || !id_valid) begin
        ex_valid      <= 1'b0;
        ex_opcode     <= '0;
        ex_reg_wren   <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_mem_wr     <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_branch     <= 1'b0;
        ex_rs         <= '0;
        ex_rt         <= '0;
        ex_dst_reg    <= '0;
        ex_rs_data    <= '0;
        ex_rt_data    <= '0;
        ex_imm        <= '0;
        ex_pc         <= '0;
      end else begin
        ex_valid      <= 1'b1;
        ex_opcode     <= id_opcode;
        ex_reg_wren   <= id_reg_wren;
        ex_mem_to_reg <= id_mem_to_reg;
        ex_mem_wr     <= id_mem_wr;
        ex_alu_src    <= id_alu_src;
        ex_branch     <= id_branch;
        ex_rs         <= id_rs;
        ex_rt         <= id_rt;
        ex_dst_reg    <= id_dst_reg_sel ? id_rd : id_rt;
        ex_rs_data    <= id_rs_data;
        ex_rt_data    <= id_rt_data;
        ex_imm        <= id_imm;
        ex_pc         <= id_pc;
      end
      if (load_bubble)
        bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the stage's transfer rules.
module tb_id_ex_stage;
  localparam int DW = 16;
  localparam int RW = 4;
  // control packing: {reg_wren, mem_to_reg, mem_wr, alu_src, dst_reg_sel, branch}
  localparam logic [5:0] C_ADD = 6'b100010;
  localparam logic [5:0] C_LW  = 6'b110100;
  localparam logic [5:0] C_SW  = 6'b001100;
  localparam logic [5:0] C_SLL = 6'b100110;

  logic clk, rst, id_valid;
  logic [3:0] id_opcode;
  logic id_reg_wren, id_mem_to_reg, id_mem_wr, id_alu_src, id_dst_reg_sel, id_branch;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc;
  logic stall_in, flush_in;
  logic ex_valid;
  logic [3:0] ex_opcode;
  logic ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_alu_src, ex_branch;
  logic [RW-1:0] ex_rs, ex_rt, ex_dst_reg;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic hazard_stall, stall_up;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic m_valid;
  logic [3:0] m_op;
  logic [4:0] m_ctl;
  logic [RW-1:0] m_rs, m_rt, m_dst;
  logic [DW-1:0] m_rsd, m_rtd, m_imm, m_pc;
  logic m_fp;
  int m_cnt;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_reg_wren(id_reg_wren), .id_mem_to_reg(id_mem_to_reg), .id_mem_wr(id_mem_wr),
    .id_alu_src(id_alu_src), .id_dst_reg_sel(id_dst_reg_sel), .id_branch(id_branch),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc(id_pc),
    .stall_in(stall_in), .flush_in(flush_in),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_reg_wren(ex_reg_wren),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_wr(ex_mem_wr), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst_reg(ex_dst_reg),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .hazard_stall(hazard_stall), .stall_up(stall_up), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_ctl = 0; m_rs = 0; m_rt = 0; m_dst = 0;
    m_rsd = 0; m_rtd = 0; m_imm = 0; m_pc = 0; m_fp = 0; m_cnt = 0;
  endtask

  // A load in EX blocks any consumer reading its (non-zero) destination.
  function automatic logic model_hazard();
    logic reads_rt;
    reads_rt = !id_alu_src || id_mem_wr;
    return id_valid && m_valid && m_ctl[3] && (m_dst != 0) &&
           ((m_dst == id_rs) || (reads_rt && m_dst == id_rt));
  endfunction

  task automatic model_edge();
    logic bub;
    if (rst) begin
      model_reset();
    end else if (stall_in) begin
      if (flush_in) m_fp = 1;
    end else begin
      bub = flush_in || m_fp || model_hazard();
      m_fp = 0;
      if (bub || !id_valid) begin
        m_valid = 0; m_op = 0; m_ctl = 0; m_rs = 0; m_rt = 0; m_dst = 0;
        m_rsd = 0; m_rtd = 0; m_imm = 0; m_pc = 0;
        if (bub && m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_valid = 1; m_op = id_opcode;
        m_ctl = {id_reg_wren, id_mem_to_reg, id_mem_wr, id_alu_src, id_branch};
        m_rs = id_rs; m_rt = id_rt; m_dst = id_dst_reg_sel ? id_rd : id_rt;
        m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm; m_pc = id_pc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_instr(input logic v, input logic [3:0] op, input logic [5:0] c,
                             input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                             input logic [RW-1:0] rd);
    id_valid = v; id_opcode = op;
    {id_reg_wren, id_mem_to_reg, id_mem_wr, id_alu_src, id_dst_reg_sel, id_branch} = c;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = DW'($urandom); id_rt_data = DW'($urandom);
    id_imm = DW'($urandom); id_pc = DW'($urandom);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      drive_instr(1, 4'h1, C_ADD, 1, 2, 3);
      flush_in = 1;
      tick();
    end
    flush_in = 0;
    drive_instr(1, 4'h0, C_ADD, 1, 2, 3);
    tick();
    checks++;
    if (bubble_cnt !== 16'd5) begin
      errors++; $display("FAIL pre_reset_cnt: got %0d expected 5", bubble_cnt);
    end
    checks++;
    if (ex_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %b expected 1", ex_valid);
    end
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if ({ex_valid, ex_reg_wren, ex_dst_reg, ex_pc, ex_rs_data, bubble_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b wren=%b dst=%0d pc=%h rsd=%h cnt=%0d expected all 0",
               ex_valid, ex_reg_wren, ex_dst_reg, ex_pc, ex_rs_data, bubble_cnt);
    end
    #1 rst = 0;
    drive_instr(1, 4'h0, C_ADD, 1, 2, 3);
    tick();
    checks++;
    if ({ex_valid, ex_opcode, ex_reg_wren, ex_dst_reg} !== {1'b1, 4'h0, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL post_reset_add: got valid=%b op=%h wren=%b dst=%0d expected 1 0 1 3",
               ex_valid, ex_opcode, ex_reg_wren, ex_dst_reg);
    end
  endtask

  task automatic test_load_use();
    drive_instr(1, 4'h8, C_LW, 1, 5, 0);
    tick();
    drive_instr(1, 4'h0, C_ADD, 5, 6, 2);
    #1;
    checks++;
    if ({hazard_stall, stall_up} !== 2'b11) begin
      errors++; $display("FAIL load_use_detect: got hz=%b up=%b expected 1 1", hazard_stall, stall_up);
    end
    tick();
    checks++;
    if ({ex_valid, ex_mem_to_reg, bubble_cnt} !== {1'b0, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL load_use_bubble: got valid=%b m2r=%b cnt=%0d expected 0 0 1",
               ex_valid, ex_mem_to_reg, bubble_cnt);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_clear: got hz=%b expected 0", hazard_stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_rs, bubble_cnt} !== {1'b1, 4'd5, 16'd1}) begin
      errors++;
      $display("FAIL load_use_resume: got valid=%b rs=%0d cnt=%0d expected 1 5 1",
               ex_valid, ex_rs, bubble_cnt);
    end
  endtask

  task automatic test_no_false_hazard();
    drive_instr(1, 4'h8, C_LW, 1, 0, 0);
    tick();
    drive_instr(1, 4'h0, C_ADD, 0, 0, 1);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL r0_no_hazard: got %b expected 0", hazard_stall);
    end
    tick();
    drive_instr(1, 4'h8, C_LW, 1, 7, 0);
    tick();
    drive_instr(1, 4'h5, C_SLL, 2, 7, 4);
    #1;
    checks++;
    if ({hazard_stall, stall_up} !== 2'b00) begin
      errors++; $display("FAIL imm_rt_no_hazard: got hz=%b up=%b expected 0 0", hazard_stall, stall_up);
    end
    tick();
    drive_instr(1, 4'h8, C_LW, 1, 7, 0);
    tick();
    drive_instr(1, 4'h9, C_SW, 1, 7, 0);
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++; $display("FAIL sw_rt_hazard: got %b expected 1", hazard_stall);
    end
    tick();
    tick();
  endtask

  task automatic test_flush();
    int c0;
    drive_instr(1, 4'h8, C_LW, 1, 4, 0);
    tick();
    drive_instr(1, 4'h1, C_ADD, 4, 2, 3);
    flush_in = 1;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++; $display("FAIL flush_hz_setup: got %b expected 1", hazard_stall);
    end
    c0 = m_cnt;
    tick();
    flush_in = 0;
    checks++;
    if ({ex_valid, bubble_cnt} !== {1'b0, 16'(c0 + 1)}) begin
      errors++; $display("FAIL flush_bubble: got valid=%b cnt=%0d expected 0 %0d", ex_valid, bubble_cnt, c0 + 1);
    end
    drive_instr(1, 4'h0, C_ADD, 1, 2, 3);
    tick();
    checks++;
    if ({ex_valid, bubble_cnt} !== {1'b1, 16'(c0 + 1)}) begin
      errors++; $display("FAIL flush_once: got valid=%b cnt=%0d expected 1 %0d", ex_valid, bubble_cnt, c0 + 1);
    end
  endtask

  task automatic test_stall_flush();
    int c0;
    logic [DW-1:0] pc_a, pc_b;
    drive_instr(1, 4'h2, C_ADD, 1, 2, 6);
    pc_a = id_pc;
    tick();
    c0 = m_cnt;
    stall_in = 1;
    flush_in = 1;
    drive_instr(1, 4'h7, C_ADD, 3, 4, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      flush_in = 0;
      checks++;
      if ({ex_valid, ex_opcode, ex_pc, bubble_cnt} !== {1'b1, 4'h2, pc_a, 16'(c0)}) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b op=%h pc=%h cnt=%0d expected 1 2 %h %0d",
                 i, ex_valid, ex_opcode, ex_pc, bubble_cnt, pc_a, c0);
      end
    end
    stall_in = 0;
    drive_instr(1, 4'h3, C_ADD, 3, 4, 5);
    pc_b = id_pc;
    tick();
    checks++;
    if ({ex_valid, bubble_cnt} !== {1'b0, 16'(c0 + 1)}) begin
      errors++; $display("FAIL pend_flush_bubble: got valid=%b cnt=%0d expected 0 %0d", ex_valid, bubble_cnt, c0 + 1);
    end
    tick();
    checks++;
    if ({ex_valid, ex_opcode, ex_pc, bubble_cnt} !== {1'b1, 4'h3, pc_b, 16'(c0 + 1)}) begin
      errors++;
      $display("FAIL pend_flush_resume: got valid=%b op=%h pc=%h cnt=%0d expected 1 3 %h %0d",
               ex_valid, ex_opcode, ex_pc, bubble_cnt, pc_b, c0 + 1);
    end
  endtask

  task automatic test_random();
    logic [9:0] act_c, exp_c;
    logic [75:0] act_d, exp_d;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (rst) model_reset();
      stall_in = ($urandom_range(0, 4) == 0);
      flush_in = ($urandom_range(0, 9) == 0);
      drive_instr(($urandom_range(0, 7) != 0), 4'($urandom), 6'($urandom),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      #1;
      checks++;
      if ({hazard_stall, stall_up} !== {model_hazard(), stall_in | model_hazard()}) begin
        errors++;
        $display("FAIL rand_hazard[%0d]: got hz=%b up=%b expected %b %b", n, hazard_stall, stall_up,
                 model_hazard(), stall_in | model_hazard());
      end
      tick();
      act_c = {ex_valid, ex_opcode, ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_alu_src, ex_branch};
      exp_c = {m_valid, m_op, m_ctl};
      checks++;
      if ({act_c, bubble_cnt} !== {exp_c, 16'(m_cnt)}) begin
        errors++;
        $display("FAIL rand_ctl[%0d]: got ctl=%h cnt=%0d expected ctl=%h cnt=%0d", n, act_c, bubble_cnt, exp_c, m_cnt);
      end
      if (m_valid) begin
        act_d = {ex_rs, ex_rt, ex_dst_reg, ex_rs_data, ex_rt_data, ex_imm, ex_pc};
        exp_d = {m_rs, m_rt, m_dst, m_rsd, m_rtd, m_imm, m_pc};
        checks++;
        if (act_d !== exp_d) begin
          errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, act_d, exp_d);
        end
      end
    end
    rst = 0; stall_in = 0; flush_in = 0;
    #1;
  endtask

  task automatic test_saturation();
    stall_in = 0;
    flush_in = 1;
    drive_instr(1, 4'h1, C_ADD, 1, 2, 3);
    repeat (65536) tick();
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach: got %h expected ffff", bubble_cnt);
    end
    repeat (3) tick();
    checks++;
    if ({ex_valid, bubble_cnt} !== {1'b0, 16'hFFFF}) begin
      errors++; $display("FAIL sat_hold: got valid=%b cnt=%h expected 0 ffff", ex_valid, bubble_cnt);
    end
    flush_in = 0;
  endtask

  initial begin
    rst = 1; stall_in = 0; flush_in = 0;
    drive_instr(0, 4'h0, 6'b0, 0, 0, 0);
    model_reset();
    repeat (2) tick();
    #2 rst = 0;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_stall_flush();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
